// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, IF/ID register and a one-entry skid buffer.
// Optional macro FETCH_INST_COUNT_EN adds num_inst, a count of instructions handed to ID.
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    output logic        i_mem_req,
    output logic [15:0] i_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        if_id_valid,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus1
`ifdef FETCH_INST_COUNT_EN
    ,
    output logic [15:0] num_inst
`endif
);

    localparam int unsigned W = 16;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] skid_q, skid_d;
    logic [W-1:0] inst_q, inst_d;
    logic [W-1:0] ipc_q, ipc_d;
    logic [W-1:0] ipc1_q, ipc1_d;
    logic         req_q, req_d;
    logic         valid_q, valid_d;
    logic [W-1:0] pc_inc;
    logic [W-1:0] pc_dec;

    assign pc_inc = pc_q + W'(1);
    // In HOLD the PC has already advanced past the buffered word
    assign pc_dec = pc_q - W'(1);

    // Next-state and next-output logic; redirect outranks halt, both ignored once halted
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        skid_d  = skid_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        ipc1_d  = ipc1_q;
        req_d   = req_q;
        valid_d = valid_q;

        if (state_q != S_HALTED && redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            skid_d  = '0;
            req_d   = 1'b1;
            state_d = S_FETCH;
        end else if (state_q != S_HALTED && halt) begin
            valid_d = 1'b0;
            req_d   = 1'b0;
            state_d = S_HALTED;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (i_mem_ack) begin
                        pc_d = pc_inc;
                        if (stall) begin
                            skid_d  = i_mem_data;
                            req_d   = 1'b0;
                            state_d = S_HOLD;
                        end else begin
                            valid_d = 1'b1;
                            inst_d  = i_mem_data;
                            ipc_d   = pc_q;
                            ipc1_d  = pc_inc;
                        end
                    end else if (!stall) begin
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        valid_d = 1'b1;
                        inst_d  = skid_q;
                        ipc_d   = pc_dec;
                        ipc1_d  = pc_q;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            skid_q  <= '0;
            inst_q  <= '0;
            ipc_q   <= '0;
            ipc1_q  <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            ipc1_q  <= ipc1_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign i_mem_req      = req_q;
    assign i_mem_addr     = pc_q;
    assign if_id_valid    = valid_q;
    assign if_id_inst     = inst_q;
    assign if_id_pc       = ipc_q;
    assign if_id_pc_plus1 = ipc1_q;

`ifdef FETCH_INST_COUNT_EN
    logic [W-1:0] cnt_q, cnt_d;

    // An instruction is consumed by ID when it is valid, not stalled and not squashed
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stall && !redirect) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign num_inst = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage against a zero-wait memory returning 16'h1000 + address.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        i_mem_req;
    logic [15:0] i_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_data;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        if_id_valid;
    logic [15:0] if_id_inst;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        ack_en;
`ifdef FETCH_INST_COUNT_EN
    logic [15:0] num_inst;
`endif

    int n_checks;
    int n_fail;

    typedef struct {
        logic        st;
        logic        rd;
        logic        ak;
        logic [15:0] rp;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_inst;
        logic [15:0] e_pc;
        logic [15:0] e_pc1;
    } vec_t;

    vec_t tbl[$];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .i_mem_req     (i_mem_req),
        .i_mem_addr    (i_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_data    (i_mem_data),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .halt          (halt),
        .if_id_valid   (if_id_valid),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_pc_plus1(if_id_pc_plus1)
`ifdef FETCH_INST_COUNT_EN
        ,
        .num_inst      (num_inst)
`endif
    );

    // Zero-wait memory: acknowledges any request in the same cycle when enabled
    assign i_mem_ack  = ack_en & i_mem_req;
    assign i_mem_data = 16'h1000 + i_mem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic rd, input logic hl, input logic ak,
                        input logic [15:0] rp);
        stall       = st;
        redirect    = rd;
        halt        = hl;
        ack_en      = ak;
        redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk({nm, " rst valid"}, 16'(if_id_valid), 16'h0000);
        chk({nm, " rst inst"}, if_id_inst, 16'h0000);
        chk({nm, " rst pc"}, if_id_pc, 16'h0000);
        chk({nm, " rst pc1"}, if_id_pc_plus1, 16'h0000);
        chk({nm, " rst addr"}, i_mem_addr, 16'h0000);
`ifdef FETCH_INST_COUNT_EN
        chk({nm, " rst num_inst"}, num_inst, 16'h0000);
`endif
        reset = 1'b0;
        chk({nm, " first req"}, 16'(i_mem_req), 16'h0001);
    endtask

    task automatic add(input logic st, input logic rd, input logic ak, input logic [15:0] rp,
                       input logic er, input logic [15:0] ea, input logic ev,
                       input logic [15:0] ei, input logic [15:0] ep, input logic [15:0] ep1);
        vec_t v;
        v.st = st; v.rd = rd; v.ak = ak; v.rp = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_inst = ei; v.e_pc = ep; v.e_pc1 = ep1;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        halt        = 1'b0;
        ack_en      = 1'b0;

        //  st    rd    ak    rp        req   addr      vld   inst      pc        pc+1
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0000, 16'h0001);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'h1001, 16'h0001, 16'h0002);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0003, 1'b1, 16'h1002, 16'h0002, 16'h0003);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h1003, 16'h0003, 16'h0004);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0005, 1'b1, 16'h1004, 16'h0004, 16'h0005);
        // ack with stall at pc 5, three stalled cycles, then release
        add(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h1004, 16'h0004, 16'h0005);
        add(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h1004, 16'h0004, 16'h0005);
        add(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'h1004, 16'h0004, 16'h0005);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0006, 1'b1, 16'h1005, 16'h0005, 16'h0006);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0007, 1'b1, 16'h1006, 16'h0006, 16'h0007);
        // stall without ack holds, then no-ack bubble
        add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b1, 16'h1006, 16'h0006, 16'h0007);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0007, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        // redirect coinciding with ack at pc 7
        add(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0041, 1'b1, 16'h1040, 16'h0040, 16'h0041);
        // wrap at 16'hFFFF
        add(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0FFF, 16'hFFFF, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b1, 16'h1000, 16'h0000, 16'h0001);
        // redirect while in HOLD discards the skid buffer
        add(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h1000, 16'h0000, 16'h0001);
        add(1'b1, 1'b1, 1'b0, 16'h0020, 1'b1, 16'h0020, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0021, 1'b1, 16'h1020, 16'h0020, 16'h0021);
        // redirect abandoning an unacknowledged request
        add(1'b0, 1'b1, 1'b0, 16'h0030, 1'b1, 16'h0030, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0031, 1'b1, 16'h1030, 16'h0030, 16'h0031);

        @(posedge clk);
        #1;
        do_reset("init");

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].rd, 1'b0, tbl[i].ak, tbl[i].rp);
            chk($sformatf("row%0d req", i), 16'(i_mem_req), 16'(tbl[i].e_req));
            chk($sformatf("row%0d addr", i), i_mem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d valid", i), 16'(if_id_valid), 16'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk($sformatf("row%0d inst", i), if_id_inst, tbl[i].e_inst);
                chk($sformatf("row%0d pc", i), if_id_pc, tbl[i].e_pc);
                chk($sformatf("row%0d pc1", i), if_id_pc_plus1, tbl[i].e_pc1);
            end
        end

        // Halt at pc 9, then every other input is ignored until reset
        do_reset("halt");
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("pre-halt addr", i_mem_addr, 16'h0009);
        chk("pre-halt inst", if_id_inst, 16'h1008);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("halt req", 16'(i_mem_req), 16'h0000);
        chk("halt valid", 16'(if_id_valid), 16'h0000);
        chk("halt addr", i_mem_addr, 16'h0009);
        for (int k = 0; k < 4; k++) begin
            step(k == 0, k == 1, k == 2, 1'b1, 16'h0055);
            chk($sformatf("halted%0d req", k), 16'(i_mem_req), 16'h0000);
            chk($sformatf("halted%0d valid", k), 16'(if_id_valid), 16'h0000);
            chk($sformatf("halted%0d addr", k), i_mem_addr, 16'h0009);
        end
        do_reset("unhalt");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("unhalt valid", 16'(if_id_valid), 16'h0001);
        chk("unhalt inst", if_id_inst, 16'h1000);
        chk("unhalt pc", if_id_pc, 16'h0000);

        // Reset while in HOLD drops the buffered word
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("hold req", 16'(i_mem_req), 16'h0000);
        do_reset("midhold");
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("midhold inst", if_id_inst, 16'h1000);
        chk("midhold pc", if_id_pc, 16'h0000);
        chk("midhold addr", i_mem_addr, 16'h0001);

`ifdef FETCH_INST_COUNT_EN
        // Ten instructions consumed across two stall cycles and one redirect
        do_reset("count");
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("count mid", num_inst, 16'h0005);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("count final", num_inst, 16'h000A);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
